ram_arbiter: RTL and testbench

Sequencing controller and arbiter for the 16 x 8-bit scratch RAM. Accepts read/write requests from NUM_REQ requesters (instruction fetch, data path, loader), grants one at a time, drives the RAM's single ADDRESS/DATA_IN/OPCODE port for exactly one access cycle, and returns read data with a one-cycle acknowledge. It sits between the CPU-side masters and the RAM; no requester touches the RAM directly.

---
 rtl/zephyr_pkg.sv | 17 +
 rtl/arb_pick.sv | 30 +++
 rtl/ram_arbiter.sv | 126 ++++++++++++
 tb/tb_ram_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/zephyr_pkg.sv
// zephyr_pkg: shared constants and types for the scratch-RAM sequencing logic.
package zephyr_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // One transaction walks IDLE -> ACCESS -> DONE -> IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage : zephyr_pkg

// File: rtl/arb_pick.sv
// arb_pick: combinational request picker. Starting at index ptr and wrapping,
// the first asserted request wins; grant is one-hot (or zero), idx its index.
module arb_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    // Scan farthest-from-ptr first so the candidate closest to ptr overwrites last.
    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise the
        // no-request path would infer latches.
        grant = '0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr) + k) % NUM_REQ;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule : arb_pick

// File: rtl/ram_arbiter.sv
// ram_arbiter: grants one requester at a time onto the single scratch-RAM port,
// performs exactly one access cycle, and returns read data with a one-cycle ACK.
// Build option: define RAM_ARB_ROUND_ROBIN_EN for rotating priority; otherwise
// fixed priority with index 0 highest.
module ram_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = zephyr_pkg::ADDR_W,
    parameter int DATA_W  = zephyr_pkg::DATA_W
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ-1:0]        OP,
    input  logic [NUM_REQ*ADDR_W-1:0] ADDR,
    input  logic [NUM_REQ*DATA_W-1:0] WDATA,
    output logic [NUM_REQ-1:0]        ACK,
    output logic [DATA_W-1:0]         RDATA,
    output logic                      BUSY,
    output logic [ADDR_W-1:0]         RAM_ADDRESS,
    output logic [DATA_W-1:0]         RAM_DATA_IN,
    output logic                      RAM_OPCODE,
    output logic                      RAM_EN,
    input  logic [DATA_W-1:0]         RAM_DATA_OUT
);

    import zephyr_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state_q;
    state_t               state_d;
    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     gnt_idx;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     win_idx_q;
    logic                 op_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W-1:0]    rdata_q;

    arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (REQ),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gnt_idx)
    );

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q;

    // Move the search start just past the requester served in DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= '0;
        end else if (state_q == DONE) begin
            ptr_q <= (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + IDX_W'(1);
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    // FSM state register.
    always_ff @(posedge CLK) begin
        // NOTE: state elements use non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: fixed three-cycle walk once a request is seen in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|grant) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the winner's transaction in IDLE; later input changes are ignored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            win_idx_q <= '0;
            op_q      <= OP_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else if (state_q == IDLE && |grant) begin
            win_idx_q <= gnt_idx;
            op_q      <= OP[gnt_idx];
            addr_q    <= ADDR[gnt_idx*ADDR_W +: ADDR_W];
            wdata_q   <= WDATA[gnt_idx*DATA_W +: DATA_W];
        end
    end

    // Read data is captured at the end of the ACCESS cycle and held until the next read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata_q <= '0;
        end else if (state_q == ACCESS && op_q == OP_READ) begin
            rdata_q <= RAM_DATA_OUT;
        end
    end

    // ACK pulses for the latched winner in DONE; suppressed during reset.
    always_comb begin
        ACK = '0;
        if (state_q == DONE && !RST) ACK[win_idx_q] = 1'b1;
    end

    // The latched registers only change on entry to ACCESS, so the RAM port
    // naturally holds its last values in the other states.
    assign RAM_ADDRESS = addr_q;
    assign RAM_DATA_IN = wdata_q;
    assign RAM_OPCODE  = op_q;
    assign RAM_EN      = (state_q == ACCESS) && !RST;
    assign RDATA       = rdata_q;
    assign BUSY        = (state_q != IDLE);

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench with a behavioural 16x8 RAM, an expectation
// queue filled by the stimulus and a negedge monitor that checks every ACK.
module tb_ram_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 8;

    typedef struct {
        int          idx;
        bit          is_read;
        logic [7:0]  rdata;
    } exp_t;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        op;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
    logic [ADDR_W-1:0]         ram_address;
    logic [DATA_W-1:0]         ram_data_in;
    logic                      ram_opcode;
    logic                      ram_en;
    logic [DATA_W-1:0]         ram_data_out;

    logic [7:0] mem [16];
    exp_t       exp_q [$];
    int         tests = 0;
    int         fails = 0;
    int         en_cycles = 0;

    ram_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .REQ          (req),
        .OP           (op),
        .ADDR         (addr),
        .WDATA        (wdata),
        .ACK          (ack),
        .RDATA        (rdata),
        .BUSY         (busy),
        .RAM_ADDRESS  (ram_address),
        .RAM_DATA_IN  (ram_data_in),
        .RAM_OPCODE   (ram_opcode),
        .RAM_EN       (ram_en),
        .RAM_DATA_OUT (ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write on the edge ending an enabled write cycle.
    assign ram_data_out = mem[ram_address];
    always @(posedge clk) begin
        if (ram_en && ram_opcode) mem[ram_address] <= ram_data_in;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every ACK pops one expectation; an ACK with nothing queued is an error.
    initial begin
        forever begin
            @(negedge clk);
            if (ram_en) en_cycles++;
            if (ack !== '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ack_onehot", 32'(ack), 32'(1) << e.idx);
                    if (e.is_read) check("rdata", 32'(rdata), 32'(e.rdata));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic o, input logic [3:0] a, input logic [7:0] d);
        op[idx]              = o;
        addr[idx*ADDR_W +: ADDR_W] = a;
        wdata[idx*DATA_W +: DATA_W] = d;
        req[idx]             = 1'b1;
    endtask

    // One full transaction from requester idx; REQ held until just after its ACK cycle.
    task automatic do_txn(input int idx, input logic o, input logic [3:0] a,
                          input logic [7:0] d, input logic [7:0] exp_rd);
        int en0;
        exp_t e;
        en0 = en_cycles;
        e.idx = idx; e.is_read = (o == 1'b0); e.rdata = exp_rd;
        exp_q.push_back(e);
        set_req(idx, o, a, d);
        tick(1);
        check("access_ram_en", 32'(ram_en), 32'h1);
        check("access_busy", 32'(busy), 32'h1);
        check("access_addr", 32'(ram_address), 32'(a));
        check("access_opcode", 32'(ram_opcode), 32'(o));
        if (o) check("access_wdata", 32'(ram_data_in), 32'(d));
        tick(1);
        check("done_ram_en", 32'(ram_en), 32'h0);
        tick(1);
        req[idx] = 1'b0;
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_addr_held", 32'(ram_address), 32'(a));
        tick(1);
        check("one_access", 32'(en_cycles - en0), 32'h1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        rst = 1'b1; req = '0; op = '0; addr = '0; wdata = '0;
        tick(2);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ram_en", 32'(ram_en), 32'h0);
        check("rst_ram_addr", 32'(ram_address), 32'h0);
        check("rst_ram_din", 32'(ram_data_in), 32'h0);
        check("rst_ram_op", 32'(ram_opcode), 32'h0);
        rst = 1'b0;
        tick(1);

        // Requester 1 writes 0xA5 to 0x3, then reads it back.
        do_txn(1, 1'b1, 4'h3, 8'hA5, 8'h00);
        do_txn(1, 1'b0, 4'h3, 8'h00, 8'hA5);
        check("write_landed", 32'(mem[3]), 32'hA5);

        // Both requesters read continuously for four transactions.
        begin
            exp_t e;
            for (int t = 0; t < 4; t++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                e.idx = t % 2;
`else
                e.idx = 0;
`endif
                e.is_read = 1'b1;
                e.rdata = (e.idx == 0) ? 8'h15 : 8'h16;
                exp_q.push_back(e);
            end
        end
        set_req(0, 1'b0, 4'h5, 8'h00);
        set_req(1, 1'b0, 4'h6, 8'h00);
        tick(12);
        req = '0;
        tick(2);
        check("contention_drained", 32'(exp_q.size()), 32'h0);

        // Address changes after the sampling edge are ignored.
        begin
            exp_t e;
            e.idx = 0; e.is_read = 1'b1; e.rdata = 8'h12;
            exp_q.push_back(e);
        end
        set_req(0, 1'b0, 4'h2, 8'h00);
        tick(1);
        addr[0 +: ADDR_W] = 4'h7;
        check("stable_addr", 32'(ram_address), 32'h2);
        tick(2);
        req[0] = 1'b0;
        tick(1);

        // Reset during the ACCESS cycle of a write: nothing committed, no ACK.
        set_req(0, 1'b1, 4'h9, 8'h5A);
        tick(1);
        rst = 1'b1;
        req[0] = 1'b0;
        #1;
        check("rst_mid_ram_en", 32'(ram_en), 32'h0);
        check("rst_mid_ack", 32'(ack), 32'h0);
        tick(1);
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_rdata", 32'(rdata), 32'h0);
        tick(4);
        check("rst_mid_no_write", 32'(mem[9]), 32'h19);
        do_txn(1, 1'b0, 4'h9, 8'h00, 8'h19);

        // REQ dropped right after sampling: still completes, exactly one access.
        begin
            int en0;
            exp_t e;
            en0 = en_cycles;
            e.idx = 0; e.is_read = 1'b1; e.rdata = 8'h14;
            exp_q.push_back(e);
            set_req(0, 1'b0, 4'h4, 8'h00);
            tick(1);
            req[0] = 1'b0;
            tick(6);
            check("drop_one_access", 32'(en_cycles - en0), 32'h1);
            check("drop_idle", 32'(busy), 32'h0);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ram_arbiter
